// File: rtl/lsu_mem_port_pkg.sv
// ------------------------------------------------------------------
// lsu_mem_port_pkg: funct3 codes, FSM states, store-enable helper. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package lsu_mem_port_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR1  = 3'd1,
    S_WR2  = 3'd2,
    S_RD   = 3'd3,
    S_RDW  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  // The enable decoder cannot take 1100, so SH at offset 2 starts with byte 2 only.
  function automatic logic [3:0] first_wen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   first_wen = 4'b0001 << off;
      2'b01:   first_wen = off[1] ? 4'b0100 : 4'b0011;
      default: first_wen = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ------------------------------------------------------------------
// lsu_load_align: extract and sign/zero-extend a load from a memory word. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lsu_load_align
  import lsu_mem_port_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rd[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_W:    result = mem_rd;
      F3_BU:   result = {24'd0, byte_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_port.sv
// ------------------------------------------------------------------
// lsu_mem_port: RV32I load/store sequencer for a byte-enabled data memory. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [3:0]  o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] load_result;
  logic        req_fire;
  logic        req_err;
  logic [1:0]  req_off;

  assign req_fire = i_req_valid & o_req_ready;
  assign req_off  = i_req_addr[1:0];

  always_comb begin
    req_err = 1'b0;
    case (i_req_funct3)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      default:                req_err = 1'b0;
    endcase
    if (i_req_we && i_req_funct3[2])                      req_err = 1'b1;
    if (i_req_funct3[1:0] == 2'b10 && req_off != 2'b00)   req_err = 1'b1;
    if (i_req_funct3[1:0] == 2'b01 && req_off[0])         req_err = 1'b1;
    if ((i_req_addr >> 2) >= DEPTH_LIMIT)                 req_err = 1'b1;
  end

  lsu_load_align u_load_align (
    .mem_rd (i_mem_rd),
    .offset (off_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      o_req_ready  <= 1'b0;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= 32'd0;
      o_resp_err   <= 1'b0;
      o_mem_addr   <= 32'd0;
      o_mem_wd     <= 32'd0;
      o_mem_wen    <= 4'd0;
      o_mem_ren    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            o_req_ready <= 1'b0;
            funct3_q    <= i_req_funct3;
            off_q       <= req_off;
            o_mem_addr  <= {i_req_addr[31:2], 2'b00};
            o_mem_wd    <= i_req_wdata << {req_off, 3'b000};
            if (req_err) begin
              state        <= S_RESP;
              o_resp_valid <= 1'b1;
              o_resp_err   <= 1'b1;
            end else if (i_req_we) begin
              state     <= S_WR1;
              o_mem_wen <= first_wen(i_req_funct3[1:0], req_off);
            end else begin
              state     <= S_RD;
              o_mem_ren <= 1'b1;
            end
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        S_WR1: begin
          if (funct3_q[1:0] == 2'b01 && off_q[1]) begin
            state     <= S_WR2;
            o_mem_wen <= 4'b1000;
          end else begin
            state        <= S_RESP;
            o_mem_wen    <= 4'd0;
            o_resp_valid <= 1'b1;
          end
        end
        S_WR2: begin
          state        <= S_RESP;
          o_mem_wen    <= 4'd0;
          o_resp_valid <= 1'b1;
        end
        S_RD: begin
          state     <= S_RDW;
          o_mem_ren <= 1'b0;
        end
        S_RDW: begin
          state        <= S_RESP;
          o_resp_rdata <= load_result;
          o_resp_valid <= 1'b1;
        end
        S_RESP: begin
          state        <= S_IDLE;
          o_resp_valid <= 1'b0;
          o_resp_rdata <= 32'd0;
          o_resp_err   <= 1'b0;
          o_mem_addr   <= 32'd0;
          o_mem_wd     <= 32'd0;
          o_req_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ------------------------------------------------------------------
// tb_lsu_mem_port: directed and random requests against a byte-level memory model. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_wen;
  logic        mem_ren;
  logic [31:0] mem_rd_q;

  always #5 clk = ~clk;

  lsu_mem_port #(.DEPTH(256)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_mem_addr   (mem_addr),
    .o_mem_wd     (mem_wd),
    .o_mem_wen    (mem_wen),
    .o_mem_ren    (mem_ren),
    .i_mem_rd     (mem_rd_q)
  );

  // Byte-addressed reference image; the word memory below is what the DUT really drives.
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] hw_mem  [0:255];
  logic        load_init;

  always @(posedge clk) begin
    if (load_init) begin
      for (int w = 0; w < 256; w++)
        hw_mem[w] <= {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    end else begin
      if (mem_ren) mem_rd_q <= hw_mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) hw_mem[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  logic [3:0]  s_wen   [1:4];
  logic        s_ren   [1:4];
  logic        s_rv    [1:4];
  logic        s_err   [1:4];
  logic        s_rdy   [1:4];
  logic [31:0] s_rdata [1:4];
  logic [31:0] s_addr  [1:4];
  logic [31:0] s_wd    [1:4];
  logic [31:0] last_rdata;

  function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int size = 1 << f3[1:0];
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    if (addr % size != 0) return 1'b1;
    if (addr / 4 >= 256) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int size = 1 << f3[1:0];
    logic [31:0] v = 32'd0;
    for (int i = 0; i < size; i++) v |= 32'(ref_mem[addr + i]) << (8*i);
    if (f3 < 3'd4 && size < 4 && v[8*size-1]) v |= 32'hFFFF_FFFF << (8*size);
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int waited = 0;
    int size = 1 << f3[1:0];
    int off = int'(addr % 4);
    int resp_at = 0, n_resp = 0, exp_lat;
    int wen_cycles = 0, ren_cycles = 0, overlap = 0, exp_wen_cycles;
    logic exp_err;
    logic [31:0] exp_rdata;
    logic [3:0] wen_union = 4'd0, exp_mask;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      s_wen[c] = mem_wen; s_ren[c] = mem_ren; s_rv[c] = resp_valid; s_err[c] = resp_err;
      s_rdy[c] = req_ready; s_rdata[c] = resp_rdata; s_addr[c] = mem_addr; s_wd[c] = mem_wd;
    end
    exp_err = ref_err(we, f3, addr);
    exp_rdata = (exp_err || we) ? 32'd0 : ref_load(f3, addr);
    exp_lat = exp_err ? 1 : (!we ? 3 : ((size == 2 && off == 2) ? 3 : 2));
    exp_mask = (exp_err || !we) ? 4'd0 : 4'(((1 << size) - 1) << off);
    exp_wen_cycles = (exp_err || !we) ? 0 : ((size == 2 && off == 2) ? 2 : 1);
    for (int c = 1; c <= 4; c++) begin
      if (s_rv[c]) begin
        n_resp++;
        if (resp_at == 0) resp_at = c;
      end
      if (s_wen[c] != 4'd0) begin
        wen_cycles++;
        wen_union |= s_wen[c];
        check("wen_addr", s_addr[c], addr & ~32'd3);
        check("wen_wdata", s_wd[c], wdata << (8*off));
      end
      if (s_ren[c]) begin
        ren_cycles++;
        check("ren_addr", s_addr[c], addr & ~32'd3);
      end
      if (s_ren[c] && s_wen[c] != 4'd0) overlap++;
    end
    check("resp_cycle", 32'(resp_at), 32'(exp_lat));
    check("resp_count", 32'(n_resp), 32'd1);
    if (resp_at != 0 && resp_at < 4) begin
      check("resp_err", 32'(s_err[resp_at]), 32'(exp_err));
      check("resp_rdata", s_rdata[resp_at], exp_rdata);
      check("ready_after_resp", 32'(s_rdy[resp_at+1]), 32'd1);
      last_rdata = s_rdata[resp_at];
    end
    check("wen_union", 32'(wen_union), 32'(exp_mask));
    check("wen_cycles", 32'(wen_cycles), 32'(exp_wen_cycles));
    check("ren_cycles", 32'(ren_cycles), (exp_err || we) ? 32'd0 : 32'd1);
    check("ren_wen_overlap", 32'(overlap), 32'd0);
    if (we && !exp_err)
      for (int i = 0; i < size; i++) ref_mem[addr + i] = wdata[8*i +: 8];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; last_rdata = 32'd0;
    for (int w = 0; w < 256; w++) begin
      logic [31:0] v;
      v = (w == 4) ? 32'h8899_AABB : $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[8*b +: 8];
    end
    repeat (3) @(negedge clk);
    load_init = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_strobes", {26'd0, resp_valid, resp_err, mem_wen}, 32'd0);
    check("rst_ren", 32'(mem_ren), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_addr_wd", mem_addr | mem_wd, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    do_req(1'b0, 3'b000, 32'h11, 32'd0);
    check("lb_value", last_rdata, 32'hFFFF_FFAA);
    check("lb_ren_t1", 32'(s_ren[1]), 32'd1);
    check("lb_addr_t1", s_addr[1], 32'h10);
    do_req(1'b0, 3'b100, 32'h11, 32'd0);
    check("lbu_value", last_rdata, 32'h0000_00AA);
    do_req(1'b0, 3'b001, 32'h12, 32'd0);
    check("lh_value", last_rdata, 32'hFFFF_8899);
    do_req(1'b0, 3'b101, 32'h12, 32'd0);
    check("lhu_value", last_rdata, 32'h0000_8899);
    do_req(1'b0, 3'b010, 32'h10, 32'd0);
    check("lw_value", last_rdata, 32'h8899_AABB);
    do_req(1'b1, 3'b001, 32'h12, 32'h0000_1234);
    check("sh2_wen_t1", 32'(s_wen[1]), 32'h4);
    check("sh2_wd_t1", s_wd[1], 32'h1234_0000);
    check("sh2_wen_t2", 32'(s_wen[2]), 32'h8);
    do_req(1'b0, 3'b010, 32'h10, 32'd0);
    check("lw_after_sh", last_rdata, 32'h1234_AABB);
    do_req(1'b1, 3'b000, 32'h13, 32'h0000_00FF);
    check("sb_wen_t1", 32'(s_wen[1]), 32'h8);
    check("sb_wd_t1", s_wd[1], 32'hFF00_0000);
    do_req(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D);
    check("sw_wen_t1", 32'(s_wen[1]), 32'hF);
    do_req(1'b1, 3'b010, 32'h13, 32'h1);
    do_req(1'b0, 3'b001, 32'h11, 32'h0);
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    do_req(1'b0, 3'b010, 32'h400, 32'h0);
    check("err_lw_oob", 32'(s_err[1]), 32'd1);

    // Reset lands at the end of the first write of a split halfword store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h12; req_wdata = 32'h0000_ABCD;
    @(posedge clk);
    #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_wr1_wen", 32'(mem_wen), 32'h4);
    @(negedge clk);
    check("rst_mid_outputs", {26'd0, resp_valid, resp_err, mem_wen}, 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    check("rst_release_ready", 32'(req_ready), 32'd1);
    ref_mem[32'h12] = 8'hCD;
    check("rst_partial_write", hw_mem[4], 32'hCACD_F00D);
    do_req(1'b0, 3'b010, 32'h10, 32'd0);

    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      we = 1'($urandom);
      f3 = 3'($urandom);
      if (we && ($urandom % 4) != 0) f3 = 3'($urandom % 3);
      a = (($urandom % 8) == 0) ? 32'($urandom_range(1024, 1100)) : 32'($urandom_range(0, 63));
      do_req(we, f3, a, $urandom);
    end

    for (int w = 0; w < 16; w++)
      check("final_mem_word", hw_mem[w],
            {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
